// File: rtl/traffic_pkg.sv
// Shared types, light encodings, selector codes and default intervals for the traffic light controller.
package traffic_pkg;

    localparam int unsigned TIME_W  = 7;
    localparam int unsigned LIGHT_W = 3;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [2:0] {
        MAIN_G     = 3'd0,
        MAIN_G_EXT = 3'd1,
        MAIN_Y     = 3'd2,
        WALK       = 3'd3,
        SIDE_G     = 3'd4,
        SIDE_G_EXT = 3'd5,
        SIDE_Y     = 3'd6
    } state_t;

    // Lamp encodings are {R,Y,G}
    localparam logic [LIGHT_W-1:0] RED = 3'b100;
    localparam logic [LIGHT_W-1:0] YEL = 3'b010;
    localparam logic [LIGHT_W-1:0] GRN = 3'b001;

    localparam logic [SEL_W-1:0] SEL_BASE = 2'b00;
    localparam logic [SEL_W-1:0] SEL_EXT  = 2'b01;
    localparam logic [SEL_W-1:0] SEL_YEL  = 2'b10;
    localparam logic [SEL_W-1:0] SEL_NONE = 2'b11;

    localparam logic [TIME_W-1:0] DEF_BASE = 7'd6;
    localparam logic [TIME_W-1:0] DEF_EXT  = 7'd3;
    localparam logic [TIME_W-1:0] DEF_YEL  = 7'd2;

    typedef struct packed {
        logic [TIME_W-1:0] base;
        logic [TIME_W-1:0] ext;
        logic [TIME_W-1:0] yel;
    } intervals_t;

endpackage

// File: rtl/time_param_regs.sv
// Programmable interval registers; a written value of zero restores that register's default.
module time_param_regs
    import traffic_pkg::*;
#(
    parameter logic [TIME_W-1:0] BASE_DEFAULT = DEF_BASE,
    parameter logic [TIME_W-1:0] EXT_DEFAULT  = DEF_EXT,
    parameter logic [TIME_W-1:0] YEL_DEFAULT  = DEF_YEL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reprogram,
    input  logic [SEL_W-1:0]  timeSelector,
    input  logic [TIME_W-1:0] timeValue,
    output intervals_t        intervals
);

    logic value_is_zero;

    assign value_is_zero = (timeValue == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            intervals <= '{base: BASE_DEFAULT, ext: EXT_DEFAULT, yel: YEL_DEFAULT};
        end else if (reprogram) begin
            case (timeSelector)
                SEL_BASE: intervals.base <= value_is_zero ? BASE_DEFAULT : timeValue;
                SEL_EXT:  intervals.ext  <= value_is_zero ? EXT_DEFAULT  : timeValue;
                SEL_YEL:  intervals.yel  <= value_is_zero ? YEL_DEFAULT  : timeValue;
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// Main/side street traffic light controller with pedestrian walk phase and an external interval timer.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter logic [TIME_W-1:0] BASE_DEFAULT = DEF_BASE,
    parameter logic [TIME_W-1:0] EXT_DEFAULT  = DEF_EXT,
    parameter logic [TIME_W-1:0] YEL_DEFAULT  = DEF_YEL
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sensor,
    input  logic               walkRequest,
    input  logic               reprogram,
    input  logic [SEL_W-1:0]   timeSelector,
    input  logic [TIME_W-1:0]  timeValue,
    input  logic               expired,
    output logic               startTimer,
    output logic [TIME_W-1:0]  timeParameter,
    output logic [LIGHT_W-1:0] mainLights,
    output logic [LIGHT_W-1:0] sideLights,
    output logic               walk
);

    state_t             state;
    state_t             state_next;
    intervals_t         intervals;
    logic               restart_q;
    logic               walk_pending;
    logic               advance;
    logic               load;
    logic               start_next;
    logic               walk_next;
    logic [TIME_W-1:0]  param_next;
    logic [LIGHT_W-1:0] main_next;
    logic [LIGHT_W-1:0] side_next;

    time_param_regs #(
        .BASE_DEFAULT (BASE_DEFAULT),
        .EXT_DEFAULT  (EXT_DEFAULT),
        .YEL_DEFAULT  (YEL_DEFAULT)
    ) u_regs (
        .clk          (clk),
        .reset        (reset),
        .reprogram    (reprogram),
        .timeSelector (timeSelector),
        .timeValue    (timeValue),
        .intervals    (intervals)
    );

    // restart_q marks a MAIN_G restart owed after reset release or after reprogram falls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= MAIN_G;
            restart_q     <= 1'b1;
            walk_pending  <= 1'b0;
            startTimer    <= 1'b0;
            timeParameter <= BASE_DEFAULT;
            mainLights    <= GRN;
            sideLights    <= RED;
            walk          <= 1'b0;
        end else begin
            state         <= state_next;
            restart_q     <= reprogram;
            startTimer    <= start_next;
            timeParameter <= param_next;
            mainLights    <= main_next;
            sideLights    <= side_next;
            walk          <= walk_next;
            if (advance && (state_next == WALK)) begin
                walk_pending <= 1'b0;
            end else if (walkRequest) begin
                walk_pending <= 1'b1;
            end
        end
    end

    // Next state: reprogram overrides everything; expired is ignored while a timer load is in flight
    always_comb begin
        state_next = state;
        advance    = 1'b0;
        if (reprogram) begin
            state_next = MAIN_G;
        end else if (expired && !startTimer && !restart_q) begin
            advance = 1'b1;
            case (state)
                MAIN_G:     state_next = sensor ? MAIN_Y : MAIN_G_EXT;
                MAIN_G_EXT: state_next = MAIN_Y;
                MAIN_Y:     state_next = walk_pending ? WALK : SIDE_G;
                WALK:       state_next = SIDE_G;
                SIDE_G:     state_next = sensor ? SIDE_G_EXT : SIDE_Y;
                SIDE_G_EXT: state_next = SIDE_Y;
                SIDE_Y:     state_next = MAIN_G;
                default:    state_next = MAIN_G;
            endcase
        end
    end

    assign load = advance | (restart_q & ~reprogram);

    // Output decode from the upcoming state so the registered lamps track the current state
    always_comb begin
        main_next  = RED;
        side_next  = RED;
        walk_next  = 1'b0;
        start_next = load;
        param_next = timeParameter;
        case (state_next)
            MAIN_G, MAIN_G_EXT: main_next = GRN;
            MAIN_Y:             main_next = YEL;
            SIDE_G, SIDE_G_EXT: side_next = GRN;
            SIDE_Y:             side_next = YEL;
            WALK:               walk_next = 1'b1;
            default:            ;
        endcase
        if (load) begin
            case (state_next)
                MAIN_Y, SIDE_Y:   param_next = intervals.yel;
                WALK, SIDE_G_EXT: param_next = intervals.ext;
                default:          param_next = intervals.base;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench: emulates the interval timer and compares against a phase-level reference model.
module tb_traffic_light_fsm;

    logic       clk = 1'b0;
    logic       reset, sensor, walkRequest, reprogram, expired;
    logic [1:0] timeSelector;
    logic [6:0] timeValue;
    logic       startTimer;
    logic [6:0] timeParameter;
    logic [2:0] mainLights, sideLights;
    logic       walk;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int P_MG = 0, P_MGE = 1, P_MY = 2, P_W = 3, P_SG = 4, P_SGE = 5, P_SY = 6;
    int m_base, m_ext, m_yel, m_phase;
    bit m_pend;

    always #5 clk = ~clk;

    traffic_light_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .sensor        (sensor),
        .walkRequest   (walkRequest),
        .reprogram     (reprogram),
        .timeSelector  (timeSelector),
        .timeValue     (timeValue),
        .expired       (expired),
        .startTimer    (startTimer),
        .timeParameter (timeParameter),
        .mainLights    (mainLights),
        .sideLights    (sideLights),
        .walk          (walk)
    );

    function automatic int m_next(int p, bit s, bit pend);
        case (p)
            P_MG:    return s ? P_MY : P_MGE;
            P_MGE:   return P_MY;
            P_MY:    return pend ? P_W : P_SG;
            P_W:     return P_SG;
            P_SG:    return s ? P_SGE : P_SY;
            P_SGE:   return P_SY;
            default: return P_MG;
        endcase
    endfunction

    function automatic logic [6:0] m_interval(int p);
        if (p == P_MY || p == P_SY) return 7'(m_yel);
        if (p == P_W || p == P_SGE) return 7'(m_ext);
        return 7'(m_base);
    endfunction

    function automatic logic [2:0] m_main(int p);
        if (p == P_MG || p == P_MGE) return 3'b001;
        if (p == P_MY) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] m_side(int p);
        if (p == P_SG || p == P_SGE) return 3'b001;
        if (p == P_SY) return 3'b010;
        return 3'b100;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0; sensor = 1'b0; walkRequest = 1'b0; reprogram = 1'b0; expired = 1'b0;
        timeSelector = 2'b00; timeValue = 7'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m_phase = P_MG; m_pend = 1'b0; m_base = 6; m_ext = 3; m_yel = 2;
    endtask

    task automatic wait_start(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (startTimer === 1'b1) seen = 1'b1;
        end
    endtask

    // One-cycle expired pulse from the emulated timer, sensor/walk sampled on the same edge
    task automatic pulse_expire(bit s, bit w);
        int nxt;
        expired = 1'b1; sensor = s; walkRequest = w;
        @(posedge clk);
        #1 expired = 1'b0; walkRequest = 1'b0;
        nxt = m_next(m_phase, s, m_pend);
        if (nxt == P_W) m_pend = 1'b0;
        else if (w) m_pend = 1'b1;
        m_phase = nxt;
    endtask

    task automatic advance(bit s, output bit ok);
        wait_start(ok);
        @(negedge clk);
        pulse_expire(s, 1'b0);
    endtask

    task automatic pulse_reprogram(logic [1:0] sel, logic [6:0] val);
        reprogram = 1'b1; timeSelector = sel; timeValue = val;
        @(posedge clk);
        #1 reprogram = 1'b0;
        m_phase = P_MG;
    endtask

    task automatic test_reset();
        reset = 1'b0; sensor = 1'b0; walkRequest = 1'b0; reprogram = 1'b0; expired = 1'b0;
        timeSelector = 2'b00; timeValue = 7'd0;
        repeat (2) @(negedge clk);
        n_checks++; if (startTimer !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b exp 0", startTimer); end
        n_checks++; if (timeParameter !== 7'd6) begin n_fail++; $display("FAIL rst_param: got %0d exp 6", timeParameter); end
        n_checks++; if (mainLights !== 3'b001 || sideLights !== 3'b100 || walk !== 1'b0) begin
            n_fail++; $display("FAIL rst_lights: got main=%b side=%b walk=%b exp 001/100/0", mainLights, sideLights, walk); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (startTimer !== 1'b1 || timeParameter !== 7'd6) begin
            n_fail++; $display("FAIL rst_release_load: got start=%b param=%0d exp 1/6", startTimer, timeParameter); end
        @(negedge clk);
        n_checks++; if (startTimer !== 1'b0 || mainLights !== 3'b001) begin
            n_fail++; $display("FAIL rst_release_drop: got start=%b main=%b exp 0/001", startTimer, mainLights); end
    endtask

    // 0: no traffic, 1: side traffic, 2: single walk request, 3: random traffic and walk requests
    task automatic test_sequences();
        bit seen, s, w;
        int nphase, walks, dly;
        for (int sc = 0; sc < 4; sc++) begin
            apply_reset();
            walks  = 0;
            nphase = (sc == 3) ? 24 : (sc == 2) ? 12 : 6;
            for (int k = 0; k < nphase; k++) begin
                wait_start(seen);
                n_checks++; if (!seen) begin n_fail++; $display("FAIL seq%0d_timeout: no startTimer in phase %0d", sc, k); break; end
                n_checks++; if (timeParameter !== m_interval(m_phase)) begin
                    n_fail++; $display("FAIL seq%0d_param k=%0d: got %0d exp %0d", sc, k, timeParameter, m_interval(m_phase)); end
                n_checks++; if (mainLights !== m_main(m_phase) || sideLights !== m_side(m_phase) || walk !== (m_phase == P_W)) begin
                    n_fail++; $display("FAIL seq%0d_lights k=%0d: got main=%b side=%b walk=%b exp %b/%b/%b",
                        sc, k, mainLights, sideLights, walk, m_main(m_phase), m_side(m_phase), m_phase == P_W); end
                if (walk === 1'b1) walks++;
                @(negedge clk);
                n_checks++; if (startTimer !== 1'b0) begin n_fail++; $display("FAIL seq%0d_strobe k=%0d: got %b exp 0", sc, k, startTimer); end
                dly = $urandom_range(0, 4);
                for (int d = 0; d < dly; d++) begin
                    if (sc == 3 && ($urandom % 4) == 0) begin
                        walkRequest = 1'b1;
                        @(posedge clk);
                        #1 walkRequest = 1'b0;
                        m_pend = 1'b1;
                    end
                    @(negedge clk);
                end
                s = (sc == 0) ? 1'b0 : (sc == 1) ? 1'b1 : 1'($urandom);
                w = (sc == 2) ? (k == 0) : (sc == 3) ? (($urandom % 3) == 0) : 1'b0;
                pulse_expire(s, w);
            end
            if (sc == 2) begin
                n_checks++; if (walks != 1) begin n_fail++; $display("FAIL walk_once: got %0d walk phases exp 1", walks); end
            end
        end
        sensor = 1'b0;
    endtask

    task automatic test_collision();
        bit seen;
        apply_reset();
        wait_start(seen);
        expired = 1'b1;
        @(posedge clk);
        #1 expired = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++; if (startTimer !== 1'b0 || mainLights !== 3'b001 || sideLights !== 3'b100) begin
                n_fail++; $display("FAIL coll_ignored: got start=%b main=%b side=%b exp 0/001/100", startTimer, mainLights, sideLights); end
        end
        pulse_expire(1'b0, 1'b0);
        wait_start(seen);
        n_checks++; if (!seen || timeParameter !== 7'd6 || mainLights !== 3'b001) begin
            n_fail++; $display("FAIL coll_ext: got seen=%b param=%0d main=%b exp 1/6/001", seen, timeParameter, mainLights); end
        @(negedge clk);
        expired = 1'b1;
        pulse_reprogram(2'b11, 7'd0);
        expired = 1'b0;
        @(negedge clk);
        n_checks++; if (startTimer !== 1'b0 || mainLights !== 3'b001) begin
            n_fail++; $display("FAIL coll_reprog_hold: got start=%b main=%b exp 0/001", startTimer, mainLights); end
        @(negedge clk);
        n_checks++; if (startTimer !== 1'b1 || timeParameter !== 7'd6) begin
            n_fail++; $display("FAIL coll_reprog_load: got start=%b param=%0d exp 1/6", startTimer, timeParameter); end
        @(negedge clk);
        pulse_expire(1'b0, 1'b0);
        wait_start(seen);
        n_checks++; if (!seen || mainLights !== 3'b001 || timeParameter !== 7'd6) begin
            n_fail++; $display("FAIL coll_reprog_state: got seen=%b main=%b param=%0d exp 1/001/6", seen, mainLights, timeParameter); end
    endtask

    task automatic test_reprogram();
        bit ok;
        apply_reset();
        for (int i = 0; i < 3; i++) advance(1'b0, ok);
        wait_start(ok);
        n_checks++; if (!ok || sideLights !== 3'b001) begin n_fail++; $display("FAIL rp_side_g: got seen=%b side=%b exp 1/001", ok, sideLights); end
        @(negedge clk);
        pulse_reprogram(2'b00, 7'd9);
        m_base = 9;
        @(negedge clk);
        n_checks++; if (mainLights !== 3'b001 || sideLights !== 3'b100 || startTimer !== 1'b0) begin
            n_fail++; $display("FAIL rp_force: got main=%b side=%b start=%b exp 001/100/0", mainLights, sideLights, startTimer); end
        @(negedge clk);
        n_checks++; if (startTimer !== 1'b1 || timeParameter !== 7'd9) begin
            n_fail++; $display("FAIL rp_base9: got start=%b param=%0d exp 1/9", startTimer, timeParameter); end
        @(negedge clk);
        pulse_expire(1'b0, 1'b0);
        wait_start(ok);
        n_checks++; if (timeParameter !== m_interval(m_phase) || mainLights !== 3'b001) begin
            n_fail++; $display("FAIL rp_ext_uses_base: got param=%0d main=%b exp %0d/001", timeParameter, mainLights, m_interval(m_phase)); end
        @(negedge clk);
        pulse_reprogram(2'b00, 7'd0);
        m_base = 6;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (startTimer !== 1'b1 || timeParameter !== 7'd6) begin
            n_fail++; $display("FAIL rp_zero_default: got start=%b param=%0d exp 1/6", startTimer, timeParameter); end
        @(negedge clk);
        reprogram = 1'b1; timeSelector = 2'b01; timeValue = 7'd5; expired = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (startTimer !== 1'b0 || mainLights !== 3'b001) begin
                n_fail++; $display("FAIL rp_held c%0d: got start=%b main=%b exp 0/001", i, startTimer, mainLights); end
        end
        reprogram = 1'b0; expired = 1'b0;
        m_ext = 5; m_phase = P_MG;
        @(negedge clk);
        n_checks++; if (startTimer !== 1'b1 || timeParameter !== 7'd6) begin
            n_fail++; $display("FAIL rp_after_fall: got start=%b param=%0d exp 1/6", startTimer, timeParameter); end
        @(negedge clk);
        pulse_expire(1'b0, 1'b1);
        advance(1'b0, ok);
        wait_start(ok);
        n_checks++; if (!ok || timeParameter !== 7'd2 || mainLights !== 3'b010) begin
            n_fail++; $display("FAIL rp_main_y: got seen=%b param=%0d main=%b exp 1/2/010", ok, timeParameter, mainLights); end
        @(negedge clk);
        pulse_expire(1'b0, 1'b0);
        wait_start(ok);
        n_checks++; if (!ok || timeParameter !== 7'd5 || walk !== 1'b1 || mainLights !== 3'b100 || sideLights !== 3'b100) begin
            n_fail++; $display("FAIL rp_walk_ext5: got seen=%b param=%0d walk=%b main=%b side=%b exp 1/5/1/100/100",
                ok, timeParameter, walk, mainLights, sideLights); end
        @(negedge clk);
        pulse_reprogram(2'b11, 7'd20);
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (startTimer !== 1'b1 || timeParameter !== 7'd6 || mainLights !== 3'b001 || walk !== 1'b0) begin
            n_fail++; $display("FAIL rp_noop_sel: got start=%b param=%0d main=%b walk=%b exp 1/6/001/0", startTimer, timeParameter, mainLights, walk); end
    endtask

    task automatic test_midreset();
        bit ok;
        apply_reset();
        for (int i = 0; i < 4; i++) advance(1'b0, ok);
        wait_start(ok);
        n_checks++; if (!ok || sideLights !== 3'b010) begin n_fail++; $display("FAIL mr_side_y: got seen=%b side=%b exp 1/010", ok, sideLights); end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0; expired = 1'b1;
        #1;
        n_checks++; if (mainLights !== 3'b001 || sideLights !== 3'b100 || walk !== 1'b0 || startTimer !== 1'b0 || timeParameter !== 7'd6) begin
            n_fail++; $display("FAIL mr_async: got main=%b side=%b walk=%b start=%b param=%0d exp 001/100/0/0/6",
                mainLights, sideLights, walk, startTimer, timeParameter); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (startTimer !== 1'b1 || timeParameter !== 7'd6) begin
            n_fail++; $display("FAIL mr_restart: got start=%b param=%0d exp 1/6", startTimer, timeParameter); end
        @(negedge clk);
        n_checks++; if (startTimer !== 1'b0 || mainLights !== 3'b001) begin
            n_fail++; $display("FAIL mr_stale_expired: got start=%b main=%b exp 0/001", startTimer, mainLights); end
        expired = 1'b0;
        @(negedge clk);
        n_checks++; if (startTimer !== 1'b0) begin n_fail++; $display("FAIL mr_single_pulse: got %b exp 0", startTimer); end
    endtask

    initial begin
        test_reset();
        test_sequences();
        test_collision();
        test_reprogram();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/traffic_light_fsm.md
TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 SHALL have parameter BASE_DEFAULT, 7'd6, base green interval in seconds.
REQ-002 SHALL have parameter EXT_DEFAULT, 7'd3, green extension and walk interval in seconds.
REQ-003 SHALL have parameter YEL_DEFAULT, 7'd2, yellow interval in seconds.
REQ-004 SHALL have port clk  in  1  single system clock (10 kHz); all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port sensor  in  1  car present on side street.
REQ-007 SHALL have port walkRequest  in  1  pedestrian button; level or pulse.
REQ-008 SHALL have port reprogram  in  1  write timeValue into the interval selected by timeSelector.
REQ-009 SHALL have port timeSelector  in  2  00 base, 01 extension, 10 yellow, 11 no-op.
REQ-010 SHALL have port timeValue  in  7  new interval in seconds.
REQ-011 SHALL have port expired  in  1  one-cycle pulse from the interval timer.
REQ-012 SHALL have port startTimer  out  1  one-cycle load strobe to the interval timer.
REQ-013 SHALL have port timeParameter  out  7  interval for the timer; valid whenever startTimer=1.
REQ-014 SHALL have port mainLights  out  3  {R,Y,G}, one-hot.
REQ-015 SHALL have port sideLights  out  3  {R,Y,G}, one-hot.
REQ-016 SHALL have port walk  out  1  pedestrian walk lamp.

Function
REQ-017 SHALL implement states MAIN_G, MAIN_G_EXT, MAIN_Y, WALK, SIDE_G, SIDE_G_EXT, SIDE_Y.
REQ-018 SHALL use these intervals: MAIN_G base, MAIN_G_EXT base, MAIN_Y yel, WALK ext, SIDE_G base, SIDE_G_EXT ext, SIDE_Y yel.
REQ-019 SHALL take transitions only on a cycle with expired=1:
  - MAIN_G to MAIN_G_EXT if sensor=0, else to MAIN_Y.
  - MAIN_G_EXT to MAIN_Y.
  - MAIN_Y to WALK if walkPending=1, else to SIDE_G.
  - WALK to SIDE_G.
  - SIDE_G to SIDE_G_EXT if sensor=1, else to SIDE_Y.
  - SIDE_G_EXT to SIDE_Y.
  - SIDE_Y to MAIN_G.
REQ-020 SHALL sample sensor only in the expired cycle.
REQ-021 SHALL, on every state transition, register startTimer=1 for exactly the first cycle of the new state, with timeParameter holding that state's interval in the same cycle.
REQ-022 SHALL ignore expired during any cycle in which startTimer=1.
REQ-023 SHALL drive lights as registered outputs consistent with the current state:
  - Main lights: G in MAIN_G and MAIN_G_EXT; Y in MAIN_Y; R otherwise.
  - Side lights: G in SIDE_G and SIDE_G_EXT; Y in SIDE_Y; R otherwise.
  - walk=1 only in WALK.
  - Never both greens at once.
REQ-024 SHALL set walkPending on walkRequest=1 and clear it on entry to WALK; if both happen in the same cycle, clear wins.
REQ-025 SHALL, on reprogram=1 with timeSelector≠11, write timeValue into the selected register; timeValue=0 writes that register's default instead.
REQ-026 SHALL, on reprogram=1 for any timeSelector value, force the state to MAIN_G and assert startTimer the next cycle using the updated base interval; reprogram has priority over expired in the same cycle.
REQ-027 SHALL, when reprogram is held high for several cycles, keep the state at MAIN_G and assert startTimer only in the cycle after reprogram falls.

Reset
REQ-028 SHALL, while reset=0, asynchronously set:
  - state to MAIN_G;
  - mainLights=001, sideLights=100, walk=0;
  - startTimer=0, timeParameter=BASE_DEFAULT;
  - walkPending=0;
  - interval registers to their defaults.
REQ-029 SHALL assert startTimer=1 with timeParameter equal to the base interval in the first clock cycle after reset rises, then 0.
REQ-030 SHALL, if reset asserts mid-interval, abandon the interval and restart per REQ-029 with no stale expired honoured.

Structure
REQ-031 SHALL place the state enum, the light encodings (RED=100, YEL=010, GRN=001), the selector codes and the default intervals in a shared package traffic_pkg.
REQ-032 SHALL implement the three interval registers, including default substitution, as sub-module time_param_regs; the FSM and the output registers live in traffic_light_fsm.

Verification
REQ-033 SHALL cover no traffic: sensor=0, expired pulsed per startTimer -> sequence MAIN_G(6), MAIN_G_EXT(6), MAIN_Y(2), SIDE_G(6), SIDE_Y(2), MAIN_G, with timeParameter values as shown.
REQ-034 SHALL cover side traffic: sensor=1 throughout -> MAIN_G(6), MAIN_Y(2), SIDE_G(6), SIDE_G_EXT(3), SIDE_Y(2).
REQ-035 SHALL cover walk: walkRequest pulse in MAIN_G -> WALK entered after MAIN_Y with walk=1, both reds, timeParameter=3; the next cycle skips WALK.
REQ-036 SHALL cover reprogram: timeSelector=00, timeValue=9 in SIDE_G -> state MAIN_G, startTimer=1 with timeParameter=9; timeValue=0 -> timeParameter=6.
REQ-037 SHALL cover reset: reset low mid SIDE_Y -> outputs at reset values immediately; startTimer pulses once with 6 after release.
REQ-038 SHALL cover collision: expired=1 in the same cycle as startTimer=1 -> no transition; expired coincident with reprogram -> MAIN_G.
